// File: rtl/logic_cell_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_cell_pkg
// Description : Mode encoding, shared golden bit function and BIST constants
//               for the logic_cell_pipe family.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_cell_pkg;

    typedef enum logic [1:0] {
        MODE_LEGACY  = 2'd0,
        MODE_AOI_INV = 2'd1,
        MODE_XOR3    = 2'd2,
        MODE_NAND3   = 2'd3
    } mode_e;

    localparam int BIST_VECTORS = 32;

    // Single-bit golden function; callers apply it across every bit of a lane.
    function automatic logic lc_eval(input logic [1:0] mode, input logic a,
                                     input logic b, input logic c);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_LEGACY:  r = (a & b) | ~c;
            MODE_AOI_INV: r = (a | b) & ~c;
            MODE_XOR3:    r = a ^ b ^ c;
            default:      r = ~(a & b & c);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_cell_stage.sv
`default_nettype none
// ============================================================================
// Module      : logic_cell_stage
// Description : One elastic register slot {valid,d,e}; loads when empty or
//               when the downstream slot takes the current beat.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_cell_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_d,
    input  logic [DW-1:0] in_e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_d,
    output logic [DW-1:0] out_e
);

    logic          r_valid;
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_e;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_d     = r_d;
    assign out_e     = r_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_e     <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_d <= in_d;
                r_e <= in_e;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_cell_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_cell_pipe
// Description : LANES x WIDTH bitwise 3-input logic cell with run-time mode,
//               followed by an elastic pipeline of STAGES slots.
//               Optional self-test enabled by macro LOGIC_CELL_BIST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_cell_pipe
    import logic_cell_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [LANES*WIDTH-1:0] in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_d,
    output logic [LANES*WIDTH-1:0] out_e,
    output logic [15:0]            beat_cnt
`ifdef LOGIC_CELL_BIST_EN
    ,
    input  logic                   bist_start,
    output logic                   bist_busy,
    output logic                   bist_pass
`endif
);

    localparam int c_dw = LANES * WIDTH;

    logic             w_busy;
    logic             w_sink_ready;
    logic             w_src_valid;
    logic [1:0]       w_src_mode;
    logic [c_dw-1:0]  w_src_a;
    logic [c_dw-1:0]  w_src_b;
    logic [c_dw-1:0]  w_src_c;
    logic [c_dw-1:0]  w_eval_d;
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [c_dw-1:0]  w_d [0:STAGES];
    logic [c_dw-1:0]  w_e [0:STAGES];
    logic [15:0]      r_beat_cnt;

    always_comb begin
        w_eval_d = '0;
        for (int i = 0; i < c_dw; i++) begin
            w_eval_d[i] = lc_eval(w_src_mode, w_src_a[i], w_src_b[i], w_src_c[i]);
        end
    end

    assign w_valid[0]      = w_src_valid;
    assign w_d[0]          = w_eval_d;
    assign w_e[0]          = ~w_src_c;
    assign w_ready[STAGES] = w_sink_ready;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic_cell_stage #(.DW(c_dw)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (w_valid[k]),
                .in_ready  (w_ready[k]),
                .in_d      (w_d[k]),
                .in_e      (w_e[k]),
                .out_valid (w_valid[k+1]),
                .out_ready (w_ready[k+1]),
                .out_d     (w_d[k+1]),
                .out_e     (w_e[k+1])
            );
        end
    endgenerate

    assign in_ready  = w_ready[0] && !w_busy;
    assign out_valid = w_valid[STAGES] && !w_busy;
    assign out_d     = w_d[STAGES];
    assign out_e     = w_e[STAGES];
    assign beat_cnt  = r_beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= 16'h0000;
        end else if (out_valid && out_ready && (r_beat_cnt != 16'hFFFF)) begin
            r_beat_cnt <= r_beat_cnt + 16'h0001;
        end
    end

`ifdef LOGIC_CELL_BIST_EN
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]      r_state;
    logic [5:0]      r_tx;
    logic [5:0]      r_rx;
    logic            r_pass;
    logic            w_pipe_empty;
    logic            w_bist_valid;
    logic            w_rx_fire;
    logic            w_rx_ok;
    logic [c_dw-1:0] w_exp_d;
    logic [c_dw-1:0] w_exp_e;

    assign w_busy       = (r_state == c_st_run) || (r_state == c_st_drain);
    assign w_pipe_empty = (w_valid[STAGES:1] == '0);
    // First vector waits for stale user beats to flush, so every later output is a BIST result.
    assign w_bist_valid = (r_state == c_st_run) && ((r_tx != 6'd0) || w_pipe_empty);

    assign w_src_valid  = w_busy ? w_bist_valid     : in_valid;
    assign w_src_mode   = w_busy ? r_tx[4:3]        : in_mode;
    assign w_src_a      = w_busy ? {c_dw{r_tx[2]}}  : in_a;
    assign w_src_b      = w_busy ? {c_dw{r_tx[1]}}  : in_b;
    assign w_src_c      = w_busy ? {c_dw{r_tx[0]}}  : in_c;
    assign w_sink_ready = w_busy | out_ready;

    assign w_rx_fire = w_busy && w_valid[STAGES] && (r_tx != 6'd0);
    assign w_exp_d   = {c_dw{lc_eval(r_rx[4:3], r_rx[2], r_rx[1], r_rx[0])}};
    assign w_exp_e   = {c_dw{~r_rx[0]}};
    assign w_rx_ok   = (w_d[STAGES] == w_exp_d) && (w_e[STAGES] == w_exp_e);

    assign bist_busy = w_busy;
    assign bist_pass = r_pass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_tx    <= 6'd0;
            r_rx    <= 6'd0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (bist_start) begin
                        r_state <= c_st_run;
                        r_tx    <= 6'd0;
                        r_rx    <= 6'd0;
                        r_pass  <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (w_bist_valid && w_ready[0]) begin
                        r_tx <= r_tx + 6'd1;
                        if (r_tx == 6'(BIST_VECTORS - 1)) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (r_rx == 6'(BIST_VECTORS)) begin
                        r_state <= c_st_done;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
            if (w_rx_fire) begin
                r_rx <= r_rx + 6'd1;
                if (!w_rx_ok) begin
                    r_pass <= 1'b0;
                end
            end
        end
    end
`else
    assign w_busy       = 1'b0;
    assign w_src_valid  = in_valid;
    assign w_src_mode   = in_mode;
    assign w_src_a      = in_a;
    assign w_src_b      = in_b;
    assign w_src_c      = in_c;
    assign w_sink_ready = out_ready;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_cell_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_cell_pipe
// Description : Self-checking bench for logic_cell_pipe using a vector-level
//               reference model and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_cell_pipe;

    localparam int WIDTH  = 8;
    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int DW     = WIDTH * LANES;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [DW-1:0] e;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_a, in_b, in_c;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_d, out_e;
    logic [15:0]   beat_cnt;
`ifdef LOGIC_CELL_BIST_EN
    logic          bist_start;
    logic          bist_busy;
    logic          bist_pass;
`endif

    beat_t exp_q[$];
    beat_t got_q[$];
    int    tests = 0;
    int    fails = 0;
    int    total_out = 0;

    always #5 clk = ~clk;

    logic_cell_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_e     (out_e),
        .beat_cnt  (beat_cnt)
`ifdef LOGIC_CELL_BIST_EN
        ,
        .bist_start(bist_start),
        .bist_busy (bist_busy),
        .bist_pass (bist_pass)
`endif
    );

    function automatic beat_t ref_beat(input logic [1:0] m, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b, input logic [DW-1:0] c);
        beat_t r;
        r.e = ~c;
        case (m)
            2'd0:    r.d = (a & b) | ~c;
            2'd1:    r.d = (a | b) & ~c;
            2'd2:    r.d = a ^ b ^ c;
            default: r.d = ~(a & b & c);
        endcase
        return r;
    endfunction

    function automatic logic [15:0] model_cnt();
        return (total_out > 65535) ? 16'hFFFF : 16'(total_out);
    endfunction

    task automatic drive_random();
        in_mode = 2'($urandom_range(0, 3));
        in_a    = $urandom;
        in_b    = $urandom;
        in_c    = $urandom;
    endtask

    // One clock: record transfers seen at both ports, then advance to 1 ns past the edge.
    task automatic tick();
        #1;
        if (in_valid && in_ready) exp_q.push_back(ref_beat(in_mode, in_a, in_b, in_c));
        if (out_valid && out_ready) begin
            got_q.push_back(beat_t'({out_d, out_e}));
            total_out++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
        tests++; if (out_d !== '0) begin fails++; $display("FAIL reset_out_d: got %h expected 0", out_d); end
        tests++; if (out_e !== '0) begin fails++; $display("FAIL reset_out_e: got %h expected 0", out_e); end
        tests++; if (beat_cnt !== 16'h0) begin fails++; $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
        // Fill the pipe with stalled beats, then reset mid-stream.
        for (int i = 0; i < 3; i++) begin drive_random(); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        exp_q.delete(); got_q.delete(); total_out = 0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid: got %0h expected 0", out_valid); end
        tests++; if (out_d !== '0) begin fails++; $display("FAIL midreset_out_d: got %h expected 0", out_d); end
        tests++; if (beat_cnt !== 16'h0) begin fails++; $display("FAIL midreset_beat_cnt: got %0d expected 0", beat_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %0h expected 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL midreset_flush: got %0d stale beats expected 0", got_q.size()); end
    endtask

    task automatic test_legacy();
        logic [2:0] v;
        int lat;
        logic [DW-1:0] exp_d, exp_e;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            in_mode = 2'd0;
            in_a = {DW{v[2]}}; in_b = {DW{v[1]}}; in_c = {DW{v[0]}};
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin tick(); lat++; end
            exp_d = v[0] ? {DW{v[2] & v[1]}} : {DW{1'b1}};
            exp_e = v[0] ? {DW{1'b0}} : {DW{1'b1}};
            tests++; if (lat != STAGES) begin fails++; $display("FAIL legacy_latency[%0d]: got %0d expected %0d", i, lat, STAGES); end
            tests++; if (out_d !== exp_d) begin fails++; $display("FAIL legacy_d[%0d]: got %h expected %h", i, out_d, exp_d); end
            tests++; if (out_e !== exp_e) begin fails++; $display("FAIL legacy_e[%0d]: got %h expected %h", i, out_e, exp_e); end
            tick();
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_streaming();
        int cycles;
        int g;
        int cnt0;
        cnt0 = total_out;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() < 100 && cycles < 400) begin
            drive_random(); in_valid = 1'b1;
            tick(); cycles++;
        end
        in_valid = 1'b0;
        g = 0;
        while (got_q.size() < exp_q.size() && g < 50) begin tick(); g++; end
        tests++; if (cycles != 100) begin fails++; $display("FAIL stream_throughput: got %0d cycles expected 100", cycles); end
        tests++; if (g != STAGES) begin fails++; $display("FAIL stream_drain: got %0d cycles expected %0d", g, STAGES); end
        tests++; if (got_q.size() != 100) begin fails++; $display("FAIL stream_count: got %0d expected 100", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL stream_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (beat_cnt !== 16'(cnt0 + 100)) begin fails++; $display("FAIL stream_beat_cnt: got %0d expected %0d", beat_cnt, cnt0 + 100); end
    endtask

    task automatic test_backpressure();
        logic          have;
        logic          stall;
        logic [DW-1:0] hd, he;
        int            g;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        have = 1'b0; hd = '0; he = '0;
        for (int i = 0; i < 10; i++) begin
            drive_random(); in_valid = 1'b1;
            tick();
            if (out_valid && !have) begin
                have = 1'b1; hd = out_d; he = out_e;
            end else if (have) begin
                tests++;
                if ({out_valid, out_d, out_e} !== {1'b1, hd, he}) begin
                    fails++; $display("FAIL bp_hold[%0d]: got %h/%h expected %h/%h", i, out_d, out_e, hd, he);
                end
            end
        end
        tests++; if (exp_q.size() != STAGES) begin fails++; $display("FAIL bp_accepted: got %0d expected %0d", exp_q.size(), STAGES); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %0h expected 0", in_ready); end
        for (int i = 0; i < 60; i++) begin
            drive_random();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            stall = out_valid && !out_ready;
            hd = out_d; he = out_e;
            tick();
            if (stall) begin
                tests++;
                if ({out_valid, out_d, out_e} !== {1'b1, hd, he}) begin
                    fails++; $display("FAIL bp_stall_hold[%0d]: got %h/%h expected %h/%h", i, out_d, out_e, hd, he);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        g = 0;
        while (got_q.size() < exp_q.size() && g < 50) begin tick(); g++; end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (beat_cnt !== model_cnt()) begin fails++; $display("FAIL bp_beat_cnt: got %0d expected %0d", beat_cnt, model_cnt()); end
        exp_q.delete(); got_q.delete();
    endtask

`ifdef LOGIC_CELL_BIST_EN
    task automatic run_bist(output int cycles, output logic leak, output logic started);
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        started = bist_busy;
        leak = 1'b0; cycles = 0;
        while (bist_busy && cycles < 400) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) leak = 1'b1;
            tick(); cycles++;
        end
    endtask

    task automatic test_bist();
        int   cyc;
        logic leak, started;
        logic [15:0] cnt_exp;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        cnt_exp = model_cnt();
        run_bist(cyc, leak, started);
        tests++; if (started !== 1'b1) begin fails++; $display("FAIL bist_busy_rise: got %0h expected 1", started); end
        tests++; if (cyc >= 400) begin fails++; $display("FAIL bist_timeout: got %0d cycles expected <400", cyc); end
        tests++; if (cyc < 32) begin fails++; $display("FAIL bist_too_short: got %0d cycles expected >=32", cyc); end
        tests++; if (leak !== 1'b0) begin fails++; $display("FAIL bist_port_isolation: got %0h expected 0", leak); end
        tests++; if (bist_pass !== 1'b1) begin fails++; $display("FAIL bist_pass_clean: got %0h expected 1", bist_pass); end
        tests++; if (beat_cnt !== cnt_exp) begin fails++; $display("FAIL bist_beat_cnt_frozen: got %0d expected %0d", beat_cnt, cnt_exp); end
        force dut.g_stage[0].u_stage.r_d = '0;
        run_bist(cyc, leak, started);
        release dut.g_stage[0].u_stage.r_d;
        tests++; if (cyc >= 400) begin fails++; $display("FAIL bist_corrupt_timeout: got %0d cycles expected <400", cyc); end
        tests++; if (bist_pass !== 1'b0) begin fails++; $display("FAIL bist_pass_corrupt: got %0h expected 0", bist_pass); end
        exp_q.delete(); got_q.delete();
    endtask
`endif

    task automatic test_saturation();
        int   guard;
        logic f;
        logic chk;
        in_valid = 1'b1; out_ready = 1'b1;
        guard = 0; chk = 1'b0;
        while (total_out < 65540 && guard < 70000) begin
            f = out_valid && out_ready;
            @(posedge clk); #1;
            if (f) total_out++;
            guard++;
            if (total_out == 65534 && !chk) begin
                chk = 1'b1;
                tests++; if (beat_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h expected fffe", beat_cnt); end
            end
        end
        tests++; if (total_out < 65540) begin fails++; $display("FAIL sat_timeout: got %0d transfers expected 65540", total_out); end
        tests++; if (beat_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_value: got %h expected ffff", beat_cnt); end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests++; if (beat_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h expected ffff", beat_cnt); end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = 2'd0; in_a = '0; in_b = '0; in_c = '0;
`ifdef LOGIC_CELL_BIST_EN
        bist_start = 1'b0;
`endif
        @(posedge clk); #1;
        test_reset();
        test_legacy();
        test_streaming();
        test_backpressure();
`ifdef LOGIC_CELL_BIST_EN
        test_bist();
`endif
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
